// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated frequency meter.
package freq_meter_pkg;

  // Measurement FSM: idle with the display blanked, or running back-to-back windows.
  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  // Largest value a 4-digit decimal display can show.
  localparam int unsigned DISP_MAX = 9999;

  // Width of the edge counter and of the X result.
  localparam int unsigned CNT_W = 14;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous input followed by a rising-edge detector.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Shift din through the synchroniser; dly_q keeps the previous synchronised value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/freq_meter_gate.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clocks and latches the
// saturated count as X for a 4-digit display, with back-to-back windows while run is high.
module freq_meter_gate
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned MAX_COUNT   = DISP_MAX,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             hold,
  input  logic             sig_in,
  output logic [CNT_W-1:0] X,
  output logic             EN,
  output logic             ovf,
  output logic             done
);

  localparam int unsigned TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]    LastTick = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MaxCnt   = CNT_W'(MAX_COUNT);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [CNT_W-1:0] x_q, x_d;
  logic             sat_q, sat_d, sat_nxt;
  logic             en_q, en_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             rise;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk (clk),
    .rst (rst),
    .din (sig_in),
    .rise(rise)
  );

  // Saturating count candidate for this cycle; also used on the window-end cycle so that
  // an edge arriving in the last cycle still lands in the latched result.
  always_comb begin
    cnt_nxt = cnt_q;
    if (rise && (cnt_q < MaxCnt)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
    sat_nxt = sat_q | (cnt_nxt == MaxCnt);
  end

  // Next-state logic for the FSM, gate timer, counter and output registers.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    x_d     = x_q;
    en_d    = en_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
        x_d     = '0;
        en_d    = 1'b0;
        ovf_d   = 1'b0;
        if (run) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!run) begin
          // Dropping run wins over a window end: partial result is thrown away.
          state_d = IDLE;
          timer_d = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          x_d     = '0;
          en_d    = 1'b0;
          ovf_d   = 1'b0;
        end else if (timer_q == LastTick) begin
          timer_d = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          if (!hold) begin
            x_d    = cnt_nxt;
            ovf_d  = sat_nxt;
            en_d   = 1'b1;
            done_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
          cnt_d   = cnt_nxt;
          sat_d   = sat_nxt;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      x_q     <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      x_q     <= x_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign X    = x_q;
  assign EN   = en_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_freq_meter_gate.sv
// Directed bench for freq_meter_gate with a 100-clock gate window. A second instance with
// MAX_COUNT=40 shares all inputs so saturation is observed alongside the default instance.
module tb_freq_meter_gate;

  localparam int unsigned Gate = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        hold;
  logic        sig_in;
  logic        man_sig;
  logic [13:0] x_a, x_b;
  logic        en_a, ovf_a, done_a;
  logic        en_b, ovf_b, done_b;

  int checks = 0;
  int errors = 0;
  int per;
  int phase;
  int n;
  int seen;

  always #5 clk = ~clk;

  freq_meter_gate #(
    .GATE_CYCLES(Gate),
    .MAX_COUNT  (9999),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .hold  (hold),
    .sig_in(sig_in),
    .X     (x_a),
    .EN    (en_a),
    .ovf   (ovf_a),
    .done  (done_a)
  );

  freq_meter_gate #(
    .GATE_CYCLES(Gate),
    .MAX_COUNT  (40),
    .SYNC_STAGES(2)
  ) u_sat (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .hold  (hold),
    .sig_in(sig_in),
    .X     (x_b),
    .EN    (en_b),
    .ovf   (ovf_b),
    .done  (done_b)
  );

  // Square-wave source: period per clocks, one rise per period; per==0 follows man_sig.
  initial begin
    sig_in = 1'b0;
    phase  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (per == 0) begin
        sig_in = man_sig;
      end else begin
        phase  = (phase + 1) % per;
        sig_in = (phase < per / 2);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Steps until done is seen at a falling edge; returns 300 if it never arrives.
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (done_a !== 1'b1 && cycles < 300);
  endtask

  initial begin
    rst     = 1'b1;
    run     = 1'b1;
    hold    = 1'b0;
    man_sig = 1'b0;
    per     = 2;

    // Reset dominates run with a toggling input.
    repeat (3) begin
      step();
      chk("rst_x", 32'(x_a), 0);
      chk("rst_en", 32'(en_a), 0);
      chk("rst_ovf", 32'(ovf_a), 0);
      chk("rst_done", 32'(done_a), 0);
    end
    rst = 1'b0;
    run = 1'b0;
    per = 10;
    repeat (20) step();
    chk("idle_en", 32'(en_a), 0);
    chk("idle_x", 32'(x_a), 0);

    // Basic measurement: 10-clock period gives 10 rises per window.
    run = 1'b1;
    wait_done(n);
    chk("win1_latency", 32'(n), 101);
    chk("win1_x", 32'(x_a), 10);
    chk("win1_en", 32'(en_a), 1);
    chk("win1_ovf", 32'(ovf_a), 0);
    chk("win1_sat_x", 32'(x_b), 10);
    chk("win1_sat_en", 32'(en_b), 1);
    step();
    chk("done_one_cycle", 32'(done_a), 0);
    // One cycle already consumed by the pulse-width check above.
    wait_done(n);
    chk("win2_latency", 32'(n), 99);
    chk("win2_x", 32'(x_a), 10);

    // Saturation: 2-clock period gives 50 rises; the MAX_COUNT=40 instance clips.
    per = 2;
    wait_done(n);
    wait_done(n);
    chk("p2_latency", 32'(n), 100);
    chk("p2_x", 32'(x_a), 50);
    chk("p2_ovf", 32'(ovf_a), 0);
    chk("p2_sat_x", 32'(x_b), 40);
    chk("p2_sat_ovf", 32'(ovf_b), 1);
    chk("p2_sat_done", 32'(done_b), 1);
    per = 10;
    wait_done(n);
    wait_done(n);
    chk("p10_x", 32'(x_a), 10);
    chk("p10_sat_x", 32'(x_b), 10);
    chk("p10_sat_ovf", 32'(ovf_b), 0);

    // Hold: two full windows at a 5-clock period must not disturb X.
    hold = 1'b1;
    per  = 5;
    seen = 0;
    repeat (200) begin
      step();
      if (done_a === 1'b1) seen++;
    end
    chk("hold_no_done", 32'(seen), 0);
    chk("hold_x", 32'(x_a), 10);
    chk("hold_en", 32'(en_a), 1);
    hold = 1'b0;
    wait_done(n);
    chk("unhold_latency", 32'(n), 100);
    chk("unhold_x", 32'(x_a), 20);
    chk("unhold_sat_x", 32'(x_b), 20);

    // Run drop at timer=50: blank next cycle, no done, then a full window on restart.
    repeat (50) step();
    run = 1'b0;
    step();
    chk("drop_en", 32'(en_a), 0);
    chk("drop_x", 32'(x_a), 0);
    chk("drop_ovf", 32'(ovf_a), 0);
    chk("drop_done", 32'(done_a), 0);
    seen = 0;
    repeat (110) begin
      step();
      if (done_a === 1'b1) seen++;
    end
    chk("drop_no_done", 32'(seen), 0);
    run = 1'b1;
    wait_done(n);
    chk("rerun_latency", 32'(n), 101);
    chk("rerun_x", 32'(x_a), 20);

    // Boundary: a single edge whose synchronised pulse lands on timer==99.
    run     = 1'b0;
    per     = 0;
    man_sig = 1'b0;
    repeat (10) step();
    run = 1'b1;
    repeat (97) step();
    man_sig = 1'b1;
    wait_done(n);
    chk("edge_latency", 32'(n), 4);
    chk("edge_x", 32'(x_a), 1);
    chk("edge_sat_x", 32'(x_b), 1);
    wait_done(n);
    chk("edge_next_latency", 32'(n), 100);
    chk("edge_next_x", 32'(x_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
